// File: rtl/hdd_sector_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdd_sector_fifo_pkg
// Purpose  : Shared constants and helpers for the HDD sector FIFO slice.
//            SECTOR_WORDS  - 16-bit words per 512-byte sector
//            DIR_HPS2IDE   - disk read direction (HPS writes, IDE reads)
//            DIR_IDE2HPS   - disk write direction (IDE writes, HPS reads)
// Revision : 1.0 - initial release
// ============================================================================
package hdd_sector_fifo_pkg;

  localparam int   SECTOR_WORDS = 256;
  localparam logic DIR_HPS2IDE  = 1'b0;
  localparam logic DIR_IDE2HPS  = 1'b1;

  // Total word capacity for a given number of sectors.
  function automatic int fifo_words(input int sectors);
    return sectors * SECTOR_WORDS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdd_sector_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : hdd_sector_fifo_if
// Purpose  : Bus bundle between the HPS/IDE sides and the sector FIFO.
//            master - control + strobes in, data/status observed
//            slave  - the FIFO itself
//            Signals: clear, dir, hps_write/hps_writedata, hps_read/
//            hps_readdata, ide_write/ide_writedata, ide_read/ide_readdata,
//            level, sector_ready, space_ready, hps_req, overflow,
//            underflow, side_err.
// Revision : 1.0 - initial release
// ============================================================================
interface hdd_sector_fifo_if #(
  parameter int SECTORS = 2
);
  import hdd_sector_fifo_pkg::*;

  localparam int WORDS = fifo_words(SECTORS);
  localparam int LW    = $clog2(WORDS) + 1;

  logic          clear;
  logic          dir;
  logic          hps_write;
  logic [15:0]   hps_writedata;
  logic          hps_read;
  logic [15:0]   hps_readdata;
  logic          ide_write;
  logic [15:0]   ide_writedata;
  logic          ide_read;
  logic [15:0]   ide_readdata;
  logic [LW-1:0] level;
  logic          sector_ready;
  logic          space_ready;
  logic          hps_req;
  logic          overflow;
  logic          underflow;
  logic          side_err;

  modport master (
    output clear, dir, hps_write, hps_writedata, hps_read,
           ide_write, ide_writedata, ide_read,
    input  hps_readdata, ide_readdata, level, sector_ready, space_ready,
           hps_req, overflow, underflow, side_err
  );

  modport slave (
    input  clear, dir, hps_write, hps_writedata, hps_read,
           ide_write, ide_writedata, ide_read,
    output hps_readdata, ide_readdata, level, sector_ready, space_ready,
           hps_req, overflow, underflow, side_err
  );

endinterface
`default_nettype wire

// File: rtl/hdd_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : hdd_fifo_ram
// Purpose  : Simple dual-port RAM, WORDS x 16, one write port and one
//            registered read port. The array itself has no reset; only the
//            read register is cleared.
//   clk_i   - clock            rst_i   - async reset of read register
//   we_i    - write enable     waddr_i - write address   wdata_i - data
//   raddr_i - read address     rdata_o - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module hdd_fifo_ram #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [15:0]   wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [15:0]   rdata_o
);

  logic [15:0] mem_q [WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hdd_sector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hdd_sector_fifo
// Purpose  : Single-direction sector buffer between the HPS word port and
//            the IDE controller, with show-ahead read data on both sides
//            and a sector-granular service request for the HPS.
//   clk_sys - system clock     reset - asynchronous active-high reset
//   bus     - hdd_sector_fifo_if.slave (strobes, data, status, flags)
// Revision : 1.0 - initial release
// ============================================================================
module hdd_sector_fifo
  import hdd_sector_fifo_pkg::*;
#(
  parameter int SECTORS = 2
) (
  input wire logic         clk_sys,
  input wire logic         reset,
  hdd_sector_fifo_if.slave bus
);

  localparam int WORDS = fifo_words(SECTORS);
  localparam int AW    = $clog2(WORDS);
  localparam int LW    = AW + 1;

  localparam logic [LW-1:0] C_FULL_LVL  = LW'(WORDS);
  localparam logic [LW-1:0] C_SECT_LVL  = LW'(SECTOR_WORDS);
  localparam logic [LW-1:0] C_SPACE_MAX = LW'(WORDS - SECTOR_WORDS);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          side_q, side_d;
  logic          dir_q;
  logic          sector_ready_q;
  logic          space_ready_q;

  logic          w_hps2ide;
  logic          w_flush;
  logic          w_push_req;
  logic          w_pop_req;
  logic          w_stray;
  logic          w_do_push;
  logic          w_do_pop;
  logic [15:0]   w_wdata;
  logic [15:0]   w_head;

  assign w_hps2ide  = (bus.dir == DIR_HPS2IDE);
  // A direction change acts as a clear in the same cycle; strobes in that
  // cycle are dropped without touching the flags.
  assign w_flush    = bus.clear | (bus.dir != dir_q);
  assign w_push_req = w_hps2ide ? bus.hps_write : bus.ide_write;
  assign w_pop_req  = w_hps2ide ? bus.ide_read  : bus.hps_read;
  assign w_stray    = w_hps2ide ? (bus.ide_write | bus.hps_read)
                                : (bus.hps_write | bus.ide_read);
  assign w_wdata    = w_hps2ide ? bus.hps_writedata : bus.ide_writedata;
  assign w_do_push  = ~w_flush & w_push_req & (level_q != C_FULL_LVL);
  assign w_do_pop   = ~w_flush & w_pop_req  & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    side_d   = side_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      side_d   = 1'b0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (w_push_req && level_q == C_FULL_LVL) ovf_d  = 1'b1;
      if (w_pop_req  && level_q == '0)         unf_d  = 1'b1;
      if (w_stray)                             side_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
      side_q         <= 1'b0;
      dir_q          <= DIR_HPS2IDE;
      sector_ready_q <= 1'b0;
      space_ready_q  <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      ovf_q          <= ovf_d;
      unf_q          <= unf_d;
      side_q         <= side_d;
      dir_q          <= bus.dir;
      sector_ready_q <= (level_d >= C_SECT_LVL);
      space_ready_q  <= (level_d <= C_SPACE_MAX);
    end
  end

  // Reading at the next-state pointer lets the head register already hold
  // the following word in the cycle after a pop.
  hdd_fifo_ram #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .we_i    (w_do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_wdata),
    .raddr_i (rd_ptr_d),
    .rdata_o (w_head)
  );

  assign bus.ide_readdata = w_hps2ide ? w_head : 16'h0000;
  assign bus.hps_readdata = w_hps2ide ? 16'h0000 : w_head;
  assign bus.level        = level_q;
  assign bus.sector_ready = sector_ready_q;
  assign bus.space_ready  = space_ready_q;
  // Uses the live dir so the request is correct right out of reset.
  assign bus.hps_req      = w_hps2ide ? space_ready_q : sector_ready_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.side_err     = side_q;

endmodule
`default_nettype wire

// File: tb/tb_hdd_sector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdd_sector_fifo
// Purpose  : Self-checking bench for hdd_sector_fifo (SECTORS=2) using a
//            word scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdd_sector_fifo;

  localparam int WORDS = 512;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  hdd_sector_fifo_if #(.SECTORS(2)) bus ();

  hdd_sector_fifo #(.SECTORS(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  logic [15:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    if (bus.dir == 1'b0) begin
      bus.hps_write     = 1'b1;
      bus.hps_writedata = d;
    end else begin
      bus.ide_write     = 1'b1;
      bus.ide_writedata = d;
    end
    if (sb.size() < WORDS) sb.push_back(d);
    tick();
    bus.hps_write = 1'b0;
    bus.ide_write = 1'b0;
  endtask

  // Waits one cycle for the head to settle, checks it, then pops.
  task automatic pop(input string tag);
    logic [15:0] head;
    logic [15:0] exp;
    tick();
    head = (bus.dir == 1'b0) ? bus.ide_readdata : bus.hps_readdata;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got 0x%0h expected scoreboard entry (none)", tag, head);
    end else begin
      exp = sb.pop_front();
      chk(tag, {16'h0, head}, {16'h0, exp});
    end
    if (bus.dir == 1'b0) bus.ide_read = 1'b1;
    else                 bus.hps_read = 1'b1;
    tick();
    bus.ide_read = 1'b0;
    bus.hps_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.clear         = 1'b0;
    bus.dir           = 1'b0;
    bus.hps_write     = 1'b0;
    bus.hps_writedata = '0;
    bus.hps_read      = 1'b0;
    bus.ide_write     = 1'b0;
    bus.ide_writedata = '0;
    bus.ide_read      = 1'b0;

    // Reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_level",  32'(bus.level), 32'd0);
    chk("rst_space",  32'(bus.space_ready), 32'd1);
    chk("rst_sector", 32'(bus.sector_ready), 32'd0);
    chk("rst_req",    32'(bus.hps_req), 32'd1);
    chk("rst_hrd",    32'(bus.hps_readdata), 32'd0);
    chk("rst_ird",    32'(bus.ide_readdata), 32'd0);
    chk("rst_flags",  32'({bus.overflow, bus.underflow, bus.side_err}), 32'd0);

    // HPS -> IDE: one sector
    for (int i = 0; i < 256; i++) push(16'(i));
    chk("s1_level",  32'(bus.level), 32'd256);
    chk("s1_sector", 32'(bus.sector_ready), 32'd1);
    chk("s1_hrd0",   32'(bus.hps_readdata), 32'd0);
    for (int i = 0; i < 256; i++) pop("s1_ide_data");
    chk("s1_level0",  32'(bus.level), 32'd0);
    chk("s1_sector0", 32'(bus.sector_ready), 32'd0);

    // IDE -> HPS: fill to capacity, then overflow
    bus.dir = 1'b1;
    tick();
    sb.delete();
    tick();
    chk("d1_level", 32'(bus.level), 32'd0);
    chk("d1_req",   32'(bus.hps_req), 32'd0);
    for (int i = 0; i < 512; i++) push(16'hA000 + 16'(i));
    chk("full_level",  32'(bus.level), 32'd512);
    chk("full_space",  32'(bus.space_ready), 32'd0);
    chk("full_sector", 32'(bus.sector_ready), 32'd1);
    chk("full_req",    32'(bus.hps_req), 32'd1);
    chk("full_ovf0",   32'(bus.overflow), 32'd0);
    push(16'hFFFF);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd512);
    pop("hps_first");
    chk("pop_level", 32'(bus.level), 32'd511);

    // Synchronous clear drops contents and flags
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    sb.delete();
    chk("clr_level", 32'(bus.level), 32'd0);
    chk("clr_ovf",   32'(bus.overflow), 32'd0);

    // Wrap: the second batch crosses the end of the RAM
    for (int i = 0; i < 300; i++) push(16'h1000 + 16'(i));
    for (int i = 0; i < 300; i++) pop("wrap1");
    for (int i = 0; i < 300; i++) push(16'h2000 + 16'(i));
    chk("wrap_level", 32'(bus.level), 32'd300);
    for (int i = 0; i < 300; i++) pop("wrap2");
    chk("wrap_level0", 32'(bus.level), 32'd0);

    // Pop on empty. Both pointers sit at 600 mod 512 = 88; that slot still
    // holds 0x1000+88 from the first batch.
    tick();
    chk("empty_head", 32'(bus.hps_readdata), 32'h1058);
    bus.hps_read = 1'b1;
    tick();
    bus.hps_read = 1'b0;
    tick();
    chk("unf_flag",  32'(bus.underflow), 32'd1);
    chk("unf_hold",  32'(bus.hps_readdata), 32'h1058);
    chk("unf_level", 32'(bus.level), 32'd0);

    // Strobe from the unselected side
    bus.hps_write     = 1'b1;
    bus.hps_writedata = 16'h5555;
    tick();
    bus.hps_write = 1'b0;
    tick();
    chk("side_flag",  32'(bus.side_err), 32'd1);
    chk("side_level", 32'(bus.level), 32'd0);

    // Level 100, then toggle dir with a push in the same cycle
    for (int i = 0; i < 100; i++) push(16'h3000 + 16'(i));
    chk("l100_level",  32'(bus.level), 32'd100);
    chk("l100_sector", 32'(bus.sector_ready), 32'd0);
    chk("l100_space",  32'(bus.space_ready), 32'd1);
    chk("l100_req",    32'(bus.hps_req), 32'd0);
    bus.dir           = 1'b0;
    bus.hps_write     = 1'b1;
    bus.hps_writedata = 16'hBEEF;
    tick();
    bus.hps_write = 1'b0;
    sb.delete();
    chk("tog_level", 32'(bus.level), 32'd0);
    chk("tog_flags", 32'({bus.overflow, bus.underflow, bus.side_err}), 32'd0);
    tick();
    chk("tog_level2", 32'(bus.level), 32'd0);
    chk("tog_req",    32'(bus.hps_req), 32'd1);
    push(16'h4242);
    pop("after_toggle");
    chk("end_level", 32'(bus.level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdd_sector_fifo.md
# hdd_sector_fifo

Sector buffer between the HPS extension bridge's HDD word port and the IDE controller. Stores 16-bit words in one direction at a time:
- disk read (HPS→IDE): HPS writes, IDE reads.
- disk write (IDE→HPS): IDE writes, HPS reads.

Generates a sector-granular service request for the HPS request byte. It also gives both readers show-ahead data, so a read strobe consumes the word already presented.

## Interface
Parameters:
- SECTORS, 2: capacity in 512-byte sectors; power of two, ≥1. WORDS = SECTORS*256.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears pointers, level, flags, output registers.
- clear  in  1  synchronous flush: pointers, level, sticky flags to 0.
- dir  in  1  0 = HPS→IDE, 1 = IDE→HPS.
- hps_write  in  1  one-cycle strobe; push hps_writedata (accepted only when dir=0).
- hps_writedata  in  16  word from HPS.
- hps_read  in  1  one-cycle strobe; pop (accepted only when dir=1).
- hps_readdata  out  16  show-ahead head word for HPS side.
- ide_write  in  1  one-cycle strobe; push ide_writedata (accepted only when dir=1).
- ide_writedata  in  16  word from IDE.
- ide_read  in  1  one-cycle strobe; pop (accepted only when dir=0).
- ide_readdata  out  16  show-ahead head word for IDE side.
- level  out  $clog2(WORDS)+1  words stored.
- sector_ready  out  1  level ≥ 256.
- space_ready  out  1  WORDS − level ≥ 256.
- hps_req  out  1  (dir=0 & space_ready) | (dir=1 & sector_ready).
- overflow  out  1  sticky: push while full.
- underflow  out  1  sticky: pop while empty.
- side_err  out  1  sticky: strobe from the side not selected by dir.

## Operation
- Storage:
  - Circular RAM of WORDS×16.
  - wr_ptr and rd_ptr, $clog2(WORDS) bits each, wrap from WORDS−1 to 0 naturally.
  - level is tracked separately.
- Push on an accepted write strobe with level<WORDS: write RAM[wr_ptr], wr_ptr+1, level+1.
- Push while full: data dropped, pointers unchanged, overflow←1.
- Pop on an accepted read strobe with level>0: rd_ptr+1, level−1.
- Pop while empty: nothing moves, readdata holds, underflow←1.
- Simultaneous accepted push and pop, with level neither 0 nor WORDS: both pointers advance, level unchanged.
  - At level 0 the pop is an underflow and only the push takes effect.
  - At level WORDS the push is an overflow and only the pop takes effect.
- Strobes from the non-selected side are ignored and set side_err.
- Show-ahead output:
  - Each cycle, the head register loads RAM[rd_ptr] (next rd_ptr if a pop occurs).
  - That value drives ide_readdata when dir=0 and hps_readdata when dir=1.
  - The unselected output is driven 0.
- dir change:
  - Detected as a change of a registered copy of dir.
  - Performs an implicit clear in the same cycle. Strobes in that cycle are discarded with no flags set.
- clear has priority over all strobes in its cycle; the sticky flags are cleared together with it.
- Status outputs (sector_ready, space_ready, hps_req) are registered, derived from the post-update level, and valid one cycle after the strobe.

## Timing
- Reset values: hps_readdata=0, ide_readdata=0, level=0, sector_ready=0, space_ready=1, hps_req=1 when dir=0 and 0 when dir=1 (first cycle after release), overflow=underflow=side_err=0.
- Write to data visible at an empty head: 2 cycles (RAM write, then head load).
- Pop to next word presented: 2 cycles.
- Consecutive pop strobes on one side must be ≥2 cycles apart. HPS strobes are far slower than this; the IDE controller guarantees it.
- Push strobes may occur every cycle.
- Reset asserted mid-transfer: immediate asynchronous clear. Contents are discarded and not recovered.

## Structure
- Shared package/header: SECTOR_WORDS=256, DIR_HPS2IDE=0, DIR_IDE2HPS=1.
- One sub-module: hdd_fifo_ram, a simple dual-port inferred RAM (one write port, one registered read port, WORDS×16, no reset on the array).
- Pointer, level, flag and request logic live in hdd_sector_fifo.

## Test plan
- Reset, dir=0 → level=0, space_ready=1, hps_req=1, sector_ready=0, both readdata=0.
- dir=0, HPS pushes 256 words 0x0000..0x00FF → sector_ready=1. IDE pops 256 words, seeing 0x0000..0x00FF in order; level returns to 0 and sector_ready=0.
- SECTORS=2, dir=1, IDE pushes 512 words → level=512, space_ready=0, hps_req=1. A 513th push sets overflow and level stays 512. HPS reads word 0 = first pushed.
- Wrap: push 300, pop 300, push 300 → readout matches the last 300 values across the pointer wrap.
- Pop on empty → underflow=1, readdata unchanged. hps_write while dir=1 → side_err=1, level unchanged.
- Level 100, toggle dir → level=0 and flags=0 next cycle. A push in the toggle cycle is discarded.
